// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial feeder.
// Included first by every serializer file.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } ser_state_t;

  localparam int WORD_CNT_W = 16;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out handshake bundle.
// slave = serializer, master = word producer.
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_last;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_bit,
    input  ser_valid,
    input  ser_last
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_bit,
    output ser_valid,
    output ser_last
  );

endinterface

// File: rtl/ser_shift_reg.sv
// Load/shift register with bit index; dout is the bit on the line.
// last flags the final bit of the loaded word.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             last
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= din;
      idx <= '0;
    end else if (shift) begin
      sr  <= MSB_FIRST ? (sr << 1) : (sr >> 1);
      idx <= idx + IW'(1);
    end
  end

  assign dout = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign last = (idx == IW'(WIDTH - 1));

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel word to serial bit stream with one-word holding register,
// optional inter-word gap and a wrapping completed-word counter.
module bit_stream_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bit_stream_serializer_if.slave bus,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_count
);

  ser_state_t       state;
  ser_state_t       state_n;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] ld_data;
  logic             hold_full;
  logic             hold_full_n;
  logic             hold_wr;
  logic             accept;
  logic             bypass;
  logic             free;
  logic             load;
  logic             shift;
  logic             gap_end;
  logic             sh_bit;
  logic             sh_last;

  assign bus.in_ready = reset_n && !hold_full;
  assign accept       = bus.in_valid && bus.in_ready;

  assign gap_end = (state == ST_GAP) && (gap_cnt == 4'(GAP - 1));
  assign free    = (state == ST_IDLE)
                || (state == ST_SHIFT && sh_last && GAP == 0)
                || gap_end;

  always_comb begin
    state_n     = state;
    load        = free && (hold_full || accept);
    bypass      = free && !hold_full && accept;
    hold_wr     = accept && !bypass;
    ld_data     = bypass ? bus.in_data : hold;
    shift       = (state == ST_SHIFT) && !sh_last;
    hold_full_n = hold_full;
    if (hold_wr)
      hold_full_n = 1'b1;
    else if (free && hold_full)
      hold_full_n = 1'b0;
    unique case (1'b1)
      load:
        state_n = ST_SHIFT;
      free && !load:
        state_n = ST_IDLE;
      state == ST_SHIFT && sh_last && !free:
        state_n = ST_GAP;
      default:
        state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      word_count <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
      hold_full <= hold_full_n;
      if (hold_wr)
        hold <= bus.in_data;
      if (state == ST_SHIFT && sh_last)
        word_count <= word_count + 1'b1;
    end
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (ld_data),
    .dout    (sh_bit),
    .last    (sh_last)
  );

  assign bus.ser_valid = (state == ST_SHIFT);
  assign bus.ser_last  = (state == ST_SHIFT) && sh_last;
  assign bus.ser_bit   = bus.ser_valid ? sh_bit : IDLE_BIT;
  assign busy          = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Two serializer configurations checked cycle by cycle against a
// word-timeline model (start/last cycle per accepted word).
module tb_bit_stream_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bit_stream_serializer_if #(.WIDTH(W)) bus0();
  bit_stream_serializer_if #(.WIDTH(W)) bus1();
  logic        busy0, busy1;
  logic [15:0] wc0, wc1;

  bit_stream_serializer #(
    .WIDTH(W), .GAP(0), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .busy(busy0), .word_count(wc0)
  );

  bit_stream_serializer #(
    .WIDTH(W), .GAP(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .busy(busy1), .word_count(wc1)
  );

  typedef struct {
    int           e;
    int           s;
    int           l;
    logic [W-1:0] d;
  } word_t;

  word_t wq[2][$];
  int compared = 0;
  int mismatched = 0;
  int edge_no = 0;

  function automatic int gapof(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic msbof(int d);
    return (d == 0);
  endfunction

  function automatic logic ibof(int d);
    return (d != 0);
  endfunction

  task automatic cmp(string name, int d, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
               name, d, edge_no, act, exp);
    end
  endtask

  task automatic sample(int d, output logic v, output logic b,
                        output logic l, output logic r,
                        output logic by, output logic [15:0] wc,
                        output logic iv, output logic [W-1:0] id);
    if (d == 0) begin
      v = bus0.ser_valid; b = bus0.ser_bit; l = bus0.ser_last;
      r = bus0.in_ready; by = busy0; wc = wc0;
      iv = bus0.in_valid; id = bus0.in_data;
    end else begin
      v = bus1.ser_valid; b = bus1.ser_bit; l = bus1.ser_last;
      r = bus1.in_ready; by = busy1; wc = wc1;
      iv = bus1.in_valid; id = bus1.in_data;
    end
  endtask

  task automatic check_dut(int d, int n);
    logic v, b, l, r, by, iv;
    logic [15:0] wc;
    logic [W-1:0] id;
    logic ev, eb, el, ehf, eby;
    int done, i, s;
    word_t w;
    sample(d, v, b, l, r, by, wc, iv, id);
    ev = 0; eb = ibof(d); el = 0; ehf = 0; eby = 0; done = 0;
    for (int k = 0; k < wq[d].size(); k++) begin
      w = wq[d][k];
      if (n >= w.s && n <= w.l) begin
        i  = n - w.s;
        ev = 1'b1;
        eb = w.d[msbof(d) ? (W - 1 - i) : i];
        el = (n == w.l);
      end
      if (w.e <= n && n < w.s) ehf = 1'b1;
      if (w.e <= n && n <= w.l + gapof(d)) eby = 1'b1;
      if (w.l < n) done++;
    end
    cmp("ser_valid", d, v, ev);
    cmp("ser_bit", d, b, eb);
    cmp("ser_last", d, l, el);
    cmp("in_ready", d, r, !ehf);
    cmp("busy", d, by, eby);
    cmp("word_count", d, wc, done & 32'hFFFF);
    if (iv && r) begin
      s = n + 1;
      if (wq[d].size() > 0 && wq[d][$].l + gapof(d) + 1 > s)
        s = wq[d][$].l + gapof(d) + 1;
      w = '{e: n + 1, s: s, l: s + W - 1, d: id};
      wq[d].push_back(w);
    end
  endtask

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      check_dut(0, edge_no);
      check_dut(1, edge_no);
    end else begin
      wq[0].delete();
      wq[1].delete();
    end
  end

  task automatic drive(int d, logic v, logic [W-1:0] x);
    if (d == 0) begin
      bus0.in_valid = v; bus0.in_data = x;
    end else begin
      bus1.in_valid = v; bus1.in_data = x;
    end
  endtask

  task automatic send(int d, logic [W-1:0] x);
    int t = 0;
    logic ok;
    drive(d, 1'b1, x);
    do begin
      @(negedge clk);
      ok = (d == 0) ? bus0.in_ready : bus1.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 60);
    cmp("accept_wait", d, ok, 1);
    drive(d, 1'b0, W'($urandom));
  endtask

  task automatic idle(int d, int c);
    repeat (c) begin
      drive(d, 1'b0, W'($urandom));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_dut(int d, int nwords);
    repeat (nwords) begin
      if ($urandom_range(3) == 0)
        idle(d, $urandom_range(1, 12));
      send(d, W'($urandom));
    end
  endtask

  task automatic reset_state_check(int d);
    logic v, b, l, r, by, iv;
    logic [15:0] wc;
    logic [W-1:0] id;
    sample(d, v, b, l, r, by, wc, iv, id);
    cmp("rst_ser_valid", d, v, 0);
    cmp("rst_ser_last", d, l, 0);
    cmp("rst_ser_bit", d, b, ibof(d));
    cmp("rst_in_ready", d, r, 0);
    cmp("rst_busy", d, by, 0);
    cmp("rst_word_count", d, wc, 0);
  endtask

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_state_check(0);
    reset_state_check(1);
    reset_n = 1'b1;
    #1;
    cmp("ready_after_release", 0, bus0.in_ready, 1);
    cmp("ready_after_release", 1, bus1.in_ready, 1);

    fork
      send(0, 8'hA5);
      send(1, 8'h01);
    join
    fork
      idle(0, 14);
      idle(1, 14);
    join
    fork
      begin send(0, 8'h0F); send(0, 8'hF0); end
      begin send(1, 8'h01); send(1, 8'h80); end
    join
    fork
      idle(0, 30);
      idle(1, 30);
    join

    fork
      run_dut(0, 300);
      run_dut(1, 200);
    join
    fork
      idle(0, 40);
      idle(1, 40);
    join

    send(0, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    reset_state_check(0);
    reset_state_check(1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fork
      idle(0, 20);
      idle(1, 20);
    join
    fork
      send(0, W'($urandom));
      send(1, W'($urandom));
    join
    fork
      idle(0, 20);
      idle(1, 20);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
